// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Provides the miss FSM state enum, address field widths and a byte-select helper.
package cache_pkg;
    localparam int ADDR_W     = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W    = 32;
    localparam int BYTE_W     = 8;
    localparam int NUM_BLOCKS = 1 << INDEX_W;
    localparam int MADDR_W    = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    function automatic logic [BYTE_W-1:0] pick_byte(
        input logic [BLOCK_W-1:0]  blk,
        input logic [OFFSET_W-1:0] off
    );
        return blk[off*BYTE_W +: BYTE_W];
    endfunction
endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bus bundles for the data cache.
// cpu_bus_if: READ/WRITE/ADDRESS/WRITEDATA in, READDATA/BUSYWAIT out of the cache.
// mem_bus_if: MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA out, MEM_READDATA/MEM_BUSYWAIT in.
interface cpu_bus_if;
    import cache_pkg::*;
    logic              READ;
    logic              WRITE;
    logic [ADDR_W-1:0] ADDRESS;
    logic [BYTE_W-1:0] WRITEDATA;
    logic [BYTE_W-1:0] READDATA;
    logic              BUSYWAIT;

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA,
        input  READDATA, BUSYWAIT
    );
    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA,
        output READDATA, BUSYWAIT
    );
endinterface

interface mem_bus_if;
    import cache_pkg::*;
    logic               MEM_READ;
    logic               MEM_WRITE;
    logic [MADDR_W-1:0] MEM_ADDRESS;
    logic [BLOCK_W-1:0] MEM_WRITEDATA;
    logic [BLOCK_W-1:0] MEM_READDATA;
    logic               MEM_BUSYWAIT;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT
    );
    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT
    );
endinterface

// File: rtl/dcache_block_array.sv
// Storage for 8 cache lines: {valid, dirty, tag, 32-bit block}.
// Ports: clk, clear (sync valid/dirty clear), idx (shared read/write index),
// async line read, byte store port (sets dirty), block fill port (valid=1, dirty=0).
module dcache_block_array
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                clear,
    input  logic [INDEX_W-1:0]  idx,
    output logic                valid,
    output logic                dirty,
    output logic [TAG_W-1:0]    tag,
    output logic [BLOCK_W-1:0]  data,
    input  logic                byte_we,
    input  logic [OFFSET_W-1:0] byte_off,
    input  logic [BYTE_W-1:0]   byte_data,
    input  logic                fill_we,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_data
);
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_mem [NUM_BLOCKS];

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_mem[idx];
    assign data  = data_mem[idx];

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (byte_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only the status bits matter.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[idx]  <= fill_tag;
            data_mem[idx] <= fill_data;
        end else if (byte_we) begin
            data_mem[idx][byte_off*BYTE_W +: BYTE_W] <= byte_data;
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache with its miss-handling FSM.
// Ports: CLK, RESET (sync, active-high), cpu (CPU load/store bus), mem (block memory bus).
module dcache_controller
    import cache_pkg::*;
(
    input  logic      CLK,
    input  logic      RESET,
    cpu_bus_if.slave  cpu,
    mem_bus_if.master mem
);
    state_t state, next_state;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic [TAG_W-1:0]    miss_tag;
    logic [INDEX_W-1:0]  miss_idx;
    logic [BLOCK_W-1:0]  fetch_buf;
    logic [INDEX_W-1:0]  arr_idx;

    logic               line_valid, line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               hit, req, byte_we, fill_we;

    assign req_tag = cpu.ADDRESS[ADDR_W-1 -: TAG_W];
    assign req_idx = cpu.ADDRESS[OFFSET_W +: INDEX_W];
    assign req_off = cpu.ADDRESS[OFFSET_W-1:0];
    assign req     = cpu.READ | cpu.WRITE;

    // Outside IDLE the line under repair is addressed by the latched miss index,
    // so a CPU that drops or changes its request cannot redirect the refill.
    assign arr_idx = (state == IDLE) ? req_idx : miss_idx;
    assign hit     = line_valid && (line_tag == req_tag);

    dcache_block_array u_array (
        .clk       (CLK),
        .clear     (RESET),
        .idx       (arr_idx),
        .valid     (line_valid),
        .dirty     (line_dirty),
        .tag       (line_tag),
        .data      (line_data),
        .byte_we   (byte_we),
        .byte_off  (req_off),
        .byte_data (cpu.WRITEDATA),
        .fill_we   (fill_we),
        .fill_tag  (miss_tag),
        .fill_data (fetch_buf)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge CLK) begin
        if (!RESET && state == IDLE && next_state != IDLE) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
        end
        if (!RESET && state == FETCH && !mem.MEM_BUSYWAIT) begin
            fetch_buf <= mem.MEM_READDATA;
        end
    end

    always_comb begin
        next_state        = state;
        cpu.BUSYWAIT      = 1'b0;
        cpu.READDATA      = '0;
        mem.MEM_READ      = 1'b0;
        mem.MEM_WRITE     = 1'b0;
        mem.MEM_ADDRESS   = '0;
        mem.MEM_WRITEDATA = '0;
        byte_we           = 1'b0;
        fill_we           = 1'b0;
        if (!RESET) begin
            cpu.READDATA = pick_byte(line_data, req_off);
            unique case (state)
                IDLE: begin
                    if (req && !hit) begin
                        cpu.BUSYWAIT = 1'b1;
                        next_state   = (line_valid && line_dirty) ? WRITEBACK : FETCH;
                    end else if (cpu.WRITE && hit) begin
                        byte_we = 1'b1;
                    end
                end
                WRITEBACK: begin
                    cpu.BUSYWAIT      = 1'b1;
                    mem.MEM_WRITE     = 1'b1;
                    mem.MEM_ADDRESS   = {line_tag, miss_idx};
                    mem.MEM_WRITEDATA = line_data;
                    if (!mem.MEM_BUSYWAIT) next_state = FETCH;
                end
                FETCH: begin
                    cpu.BUSYWAIT    = 1'b1;
                    mem.MEM_READ    = 1'b1;
                    mem.MEM_ADDRESS = {miss_tag, miss_idx};
                    if (!mem.MEM_BUSYWAIT) next_state = UPDATE;
                end
                UPDATE: begin
                    cpu.BUSYWAIT = 1'b1;
                    fill_we      = 1'b1;
                    next_state   = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller.
// Drives the CPU and memory buses from tasks; checks at negedge + 1.
module tb_dcache_controller;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    cpu_bus_if cpu();
    mem_bus_if mem();

    dcache_controller dut (
        .CLK   (clk),
        .RESET (rst),
        .cpu   (cpu),
        .mem   (mem)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!done) begin
            checks++;
            if (mem.MEM_READ === 1'b1 && mem.MEM_WRITE === 1'b1) begin
                failures++;
                $display("FAIL mem_excl got rd=%b wr=%b exp not both 1",
                         mem.MEM_READ, mem.MEM_WRITE);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu.READ = 1'b1;
        cpu.WRITE = 1'b0;
        cpu.ADDRESS = 8'h05;
        cpu.WRITEDATA = 8'h00;
        mem.MEM_BUSYWAIT = 1'b1;
        mem.MEM_READDATA = 32'h0;
        step();
        step();
        checks++;
        if (cpu.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy got=%b exp=0", cpu.BUSYWAIT);
        end
        checks++;
        if ({mem.MEM_READ, mem.MEM_WRITE} !== 2'b00) begin
            failures++;
            $display("FAIL rst_memreq got=%b exp=00", {mem.MEM_READ, mem.MEM_WRITE});
        end
        checks++;
        if (mem.MEM_ADDRESS !== 6'h00 || mem.MEM_WRITEDATA !== 32'h0) begin
            failures++;
            $display("FAIL rst_memaddr got=%h/%h exp=00/0", mem.MEM_ADDRESS, mem.MEM_WRITEDATA);
        end
        checks++;
        if (cpu.READDATA !== 8'h00) begin
            failures++;
            $display("FAIL rst_rdata got=%h exp=00", cpu.READDATA);
        end
    endtask

    task automatic test_read_miss();
        rst = 1'b0;
        #1;
        checks++;
        if (cpu.BUSYWAIT !== 1'b1 || mem.MEM_READ !== 1'b0) begin
            failures++;
            $display("FAIL t1_idle_miss got busy=%b rd=%b exp 1 0", cpu.BUSYWAIT, mem.MEM_READ);
        end
        step();
        checks++;
        if (mem.MEM_READ !== 1'b1 || mem.MEM_WRITE !== 1'b0 || mem.MEM_ADDRESS !== 6'h01) begin
            failures++;
            $display("FAIL t1_fetch got rd=%b wr=%b a=%h exp 1 0 01",
                     mem.MEM_READ, mem.MEM_WRITE, mem.MEM_ADDRESS);
        end
        step();
        step();
        step();
        checks++;
        if (mem.MEM_READ !== 1'b1 || cpu.BUSYWAIT !== 1'b1) begin
            failures++;
            $display("FAIL t1_fetch_hold got rd=%b busy=%b exp 1 1", mem.MEM_READ, cpu.BUSYWAIT);
        end
        mem.MEM_BUSYWAIT = 1'b0;
        mem.MEM_READDATA = 32'h44332211;
        step();
        mem.MEM_BUSYWAIT = 1'b1;
        #1;
        checks++;
        if (mem.MEM_READ !== 1'b0 || mem.MEM_WRITE !== 1'b0 || cpu.BUSYWAIT !== 1'b1) begin
            failures++;
            $display("FAIL t1_update got rd=%b wr=%b busy=%b exp 0 0 1",
                     mem.MEM_READ, mem.MEM_WRITE, cpu.BUSYWAIT);
        end
        step();
        checks++;
        if (cpu.BUSYWAIT !== 1'b0 || cpu.READDATA !== 8'h22) begin
            failures++;
            $display("FAIL t1_hit got busy=%b rd=%h exp 0 22", cpu.BUSYWAIT, cpu.READDATA);
        end
    endtask

    task automatic test_write_hit();
        cpu.READ = 1'b0;
        cpu.WRITE = 1'b1;
        cpu.WRITEDATA = 8'hAA;
        #1;
        checks++;
        if (cpu.BUSYWAIT !== 1'b0 || {mem.MEM_READ, mem.MEM_WRITE} !== 2'b00) begin
            failures++;
            $display("FAIL t2_whit got busy=%b mem=%b exp 0 00",
                     cpu.BUSYWAIT, {mem.MEM_READ, mem.MEM_WRITE});
        end
        step();
        cpu.WRITE = 1'b0;
        cpu.READ = 1'b1;
        #1;
        checks++;
        if (cpu.READDATA !== 8'hAA || cpu.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("FAIL t2_readback got rd=%h busy=%b exp AA 0", cpu.READDATA, cpu.BUSYWAIT);
        end
    endtask

    task automatic test_dirty_miss();
        cpu.ADDRESS = 8'h25;
        #1;
        checks++;
        if (cpu.BUSYWAIT !== 1'b1) begin
            failures++;
            $display("FAIL t3_miss got busy=%b exp 1", cpu.BUSYWAIT);
        end
        step();
        checks++;
        if (mem.MEM_WRITE !== 1'b1 || mem.MEM_READ !== 1'b0 || mem.MEM_ADDRESS !== 6'h01) begin
            failures++;
            $display("FAIL t3_wb got wr=%b rd=%b a=%h exp 1 0 01",
                     mem.MEM_WRITE, mem.MEM_READ, mem.MEM_ADDRESS);
        end
        checks++;
        if (mem.MEM_WRITEDATA !== 32'h4433AA11) begin
            failures++;
            $display("FAIL t3_wbdata got=%h exp=4433aa11", mem.MEM_WRITEDATA);
        end
        step();
        checks++;
        if (mem.MEM_WRITE !== 1'b1) begin
            failures++;
            $display("FAIL t3_wb_hold got wr=%b exp 1", mem.MEM_WRITE);
        end
        mem.MEM_BUSYWAIT = 1'b0;
        step();
        mem.MEM_BUSYWAIT = 1'b1;
        #1;
        checks++;
        if (mem.MEM_READ !== 1'b1 || mem.MEM_WRITE !== 1'b0 || mem.MEM_ADDRESS !== 6'h09) begin
            failures++;
            $display("FAIL t3_fetch got rd=%b wr=%b a=%h exp 1 0 09",
                     mem.MEM_READ, mem.MEM_WRITE, mem.MEM_ADDRESS);
        end
        mem.MEM_BUSYWAIT = 1'b0;
        mem.MEM_READDATA = 32'hDDCCBBAA;
        step();
        mem.MEM_BUSYWAIT = 1'b1;
        step();
        checks++;
        if (cpu.READDATA !== 8'hBB || cpu.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("FAIL t3_hit got rd=%h busy=%b exp BB 0", cpu.READDATA, cpu.BUSYWAIT);
        end
    endtask

    task automatic test_clean_miss();
        cpu.ADDRESS = 8'h45;
        #1;
        checks++;
        if (cpu.BUSYWAIT !== 1'b1 || mem.MEM_WRITE !== 1'b0) begin
            failures++;
            $display("FAIL t4_miss got busy=%b wr=%b exp 1 0", cpu.BUSYWAIT, mem.MEM_WRITE);
        end
        step();
        checks++;
        if (mem.MEM_READ !== 1'b1 || mem.MEM_WRITE !== 1'b0 || mem.MEM_ADDRESS !== 6'h11) begin
            failures++;
            $display("FAIL t4_fetch got rd=%b wr=%b a=%h exp 1 0 11",
                     mem.MEM_READ, mem.MEM_WRITE, mem.MEM_ADDRESS);
        end
        mem.MEM_BUSYWAIT = 1'b0;
        mem.MEM_READDATA = 32'h0D0C0B0A;
        step();
        mem.MEM_BUSYWAIT = 1'b1;
        step();
        checks++;
        if (cpu.READDATA !== 8'h0B || cpu.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("FAIL t4_hit got rd=%h busy=%b exp 0B 0", cpu.READDATA, cpu.BUSYWAIT);
        end
    endtask

    task automatic test_reset_mid_miss();
        cpu.ADDRESS = 8'h25;
        step();
        checks++;
        if (mem.MEM_READ !== 1'b1 || mem.MEM_ADDRESS !== 6'h09) begin
            failures++;
            $display("FAIL t5_fetch got rd=%b a=%h exp 1 09", mem.MEM_READ, mem.MEM_ADDRESS);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem.MEM_READ !== 1'b0 || cpu.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("FAIL t5_rst_out got rd=%b busy=%b exp 0 0", mem.MEM_READ, cpu.BUSYWAIT);
        end
        step();
        rst = 1'b0;
        cpu.READ = 1'b0;
        #1;
        checks++;
        if (mem.MEM_READ !== 1'b0 || mem.MEM_WRITE !== 1'b0 || cpu.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("FAIL t5_idle got rd=%b wr=%b busy=%b exp 0 0 0",
                     mem.MEM_READ, mem.MEM_WRITE, cpu.BUSYWAIT);
        end
        cpu.READ = 1'b1;
        cpu.ADDRESS = 8'h45;
        #1;
        checks++;
        if (cpu.BUSYWAIT !== 1'b1) begin
            failures++;
            $display("FAIL t5_inval got busy=%b exp 1", cpu.BUSYWAIT);
        end
        step();
        checks++;
        if (mem.MEM_READ !== 1'b1 || mem.MEM_WRITE !== 1'b0 || mem.MEM_ADDRESS !== 6'h11) begin
            failures++;
            $display("FAIL t5_refetch got rd=%b wr=%b a=%h exp 1 0 11",
                     mem.MEM_READ, mem.MEM_WRITE, mem.MEM_ADDRESS);
        end
        mem.MEM_BUSYWAIT = 1'b0;
        mem.MEM_READDATA = 32'h04030201;
        step();
        mem.MEM_BUSYWAIT = 1'b1;
        step();
        checks++;
        if (cpu.READDATA !== 8'h02 || cpu.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("FAIL t5_hit got rd=%h busy=%b exp 02 0", cpu.READDATA, cpu.BUSYWAIT);
        end
    endtask

    task automatic test_read_write_both();
        cpu.WRITE = 1'b1;
        cpu.WRITEDATA = 8'h5A;
        #1;
        checks++;
        if (cpu.BUSYWAIT !== 1'b0 || {mem.MEM_READ, mem.MEM_WRITE} !== 2'b00) begin
            failures++;
            $display("FAIL t6_both got busy=%b mem=%b exp 0 00",
                     cpu.BUSYWAIT, {mem.MEM_READ, mem.MEM_WRITE});
        end
        step();
        cpu.WRITE = 1'b0;
        #1;
        checks++;
        if (cpu.READDATA !== 8'h5A) begin
            failures++;
            $display("FAIL t6_readback got=%h exp=5A", cpu.READDATA);
        end
    endtask

    task automatic test_dropped_request();
        cpu.ADDRESS = 8'h25;
        step();
        checks++;
        if (mem.MEM_WRITE !== 1'b1 || mem.MEM_ADDRESS !== 6'h11 ||
            mem.MEM_WRITEDATA !== 32'h04035A01) begin
            failures++;
            $display("FAIL t7_wb got wr=%b a=%h d=%h exp 1 11 04035a01",
                     mem.MEM_WRITE, mem.MEM_ADDRESS, mem.MEM_WRITEDATA);
        end
        mem.MEM_BUSYWAIT = 1'b0;
        step();
        mem.MEM_BUSYWAIT = 1'b1;
        cpu.READ = 1'b0;
        cpu.ADDRESS = 8'h99;
        #1;
        checks++;
        if (mem.MEM_READ !== 1'b1 || mem.MEM_ADDRESS !== 6'h09 || cpu.BUSYWAIT !== 1'b1) begin
            failures++;
            $display("FAIL t7_fetch got rd=%b a=%h busy=%b exp 1 09 1",
                     mem.MEM_READ, mem.MEM_ADDRESS, cpu.BUSYWAIT);
        end
        mem.MEM_BUSYWAIT = 1'b0;
        mem.MEM_READDATA = 32'h99887766;
        step();
        mem.MEM_BUSYWAIT = 1'b1;
        step();
        checks++;
        if (cpu.BUSYWAIT !== 1'b0 || {mem.MEM_READ, mem.MEM_WRITE} !== 2'b00) begin
            failures++;
            $display("FAIL t7_idle got busy=%b mem=%b exp 0 00",
                     cpu.BUSYWAIT, {mem.MEM_READ, mem.MEM_WRITE});
        end
        cpu.READ = 1'b1;
        cpu.ADDRESS = 8'h25;
        #1;
        checks++;
        if (cpu.BUSYWAIT !== 1'b0 || cpu.READDATA !== 8'h77) begin
            failures++;
            $display("FAIL t7_hit got busy=%b rd=%h exp 0 77", cpu.BUSYWAIT, cpu.READDATA);
        end
        cpu.READ = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_miss();
        test_clean_miss();
        test_reset_mid_miss();
        test_read_write_both();
        test_dropped_request();
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
